// File: rtl/clarvi_avalon_timer.sv
// Avalon-MM timer: 64-bit prescaled mtime, 64-bit mtimecmp and a level interrupt.
// Reads have a fixed 1-cycle latency; a read of MTIME_LO latches MTIME_HI for an atomic 64-bit read.
module clarvi_avalon_timer #(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avs_s0_address,
  input  logic [3:0]            avs_s0_byteenable,
  input  logic                  avs_s0_read,
  output logic [31:0]           avs_s0_readdata,
  output logic                  avs_s0_readdatavalid,
  input  logic                  avs_s0_write,
  input  logic [31:0]           avs_s0_writedata,
  output logic                  avs_s0_waitrequest,
  output logic                  inr_irq
);

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  pcount_q, pcount_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        irq_q, irq_d;

  logic [31:0] addr;
  logic        rd_acc;
  logic        wr_acc;
  logic        cmp_ge;
  logic        tick;
  logic [31:0] rmux;

  assign addr   = 32'(avs_s0_address);
  assign wr_acc = avs_s0_write;
  // A simultaneous write drops the read.
  assign rd_acc = avs_s0_read & ~avs_s0_write;
  assign cmp_ge = (mtime_q >= mtimecmp_q);
  assign tick   = en_q & (pcount_q == prescale_q);

  always_comb begin
    rmux = 32'd0;
    case (addr)
      32'd0:   rmux = mtime_q[31:0];
      32'd1:   rmux = hi_shadow_q;
      32'd2:   rmux = mtimecmp_q[31:0];
      32'd3:   rmux = mtimecmp_q[63:32];
      32'd4:   rmux = {16'd0, prescale_q, 6'd0, irq_en_q, en_q};
      32'd5:   rmux = {31'd0, cmp_ge};
      default: rmux = 32'd0;
    endcase
  end

  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    prescale_d  = prescale_q;
    pcount_d    = pcount_q;
    hi_shadow_d = hi_shadow_q;
    rdata_d     = rdata_q;
    rvalid_d    = rd_acc;
    irq_d       = irq_en_q & cmp_ge;

    if (en_q) pcount_d = tick ? 8'd0 : pcount_q + 8'd1;

    // A write to either mtime half suppresses that cycle's increment.
    if (wr_acc && addr == 32'd0) begin
      mtime_d[31:0] = merge_lanes(mtime_q[31:0], avs_s0_writedata, avs_s0_byteenable);
    end else if (wr_acc && addr == 32'd1) begin
      mtime_d[63:32] = merge_lanes(mtime_q[63:32], avs_s0_writedata, avs_s0_byteenable);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_acc) begin
      case (addr)
        32'd2: mtimecmp_d[31:0] = merge_lanes(mtimecmp_q[31:0], avs_s0_writedata,
                                              avs_s0_byteenable);
        32'd3: mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], avs_s0_writedata,
                                               avs_s0_byteenable);
        32'd4: begin
          if (avs_s0_byteenable[0]) begin
            en_d     = avs_s0_writedata[0];
            irq_en_d = avs_s0_writedata[1];
          end
          if (avs_s0_byteenable[1]) prescale_d = avs_s0_writedata[15:8];
        end
        default: ;
      endcase
    end

    if (rd_acc) begin
      rdata_d = rmux;
      if (addr == 32'd0) hi_shadow_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= '1;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      prescale_q  <= 8'd0;
      pcount_q    <= 8'd0;
      hi_shadow_q <= 32'd0;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      prescale_q  <= prescale_d;
      pcount_q    <= pcount_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      irq_q       <= irq_d;
    end
  end

  // Gating by reset suppresses a response still pending when reset arrives.
  assign avs_s0_waitrequest   = reset;
  assign avs_s0_readdatavalid = rvalid_q & ~reset;
  assign avs_s0_readdata      = reset ? 32'd0 : rdata_q;
  assign inr_irq              = irq_q & ~reset;

endmodule

// File: tb/tb_clarvi_avalon_timer.sv
// Self-checking bench for clarvi_avalon_timer: per-cycle reference model plus directed literals.
module tb_clarvi_avalon_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [3:0]  byteenable = 4'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        irq;

  int checks = 0;
  int errors = 0;

  clarvi_avalon_timer #(.ADDR_WIDTH(3)) dut (
    .clock               (clock),
    .reset               (reset),
    .avs_s0_address      (address),
    .avs_s0_byteenable   (byteenable),
    .avs_s0_read         (read),
    .avs_s0_readdata     (readdata),
    .avs_s0_readdatavalid(readdatavalid),
    .avs_s0_write        (write),
    .avs_s0_writedata    (writedata),
    .avs_s0_waitrequest  (waitrequest),
    .inr_irq             (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: whole-register view of the timer.
  logic [63:0] m_time = 64'd0;
  logic [63:0] m_cmp = '1;
  logic        m_en = 1'b0;
  logic        m_ien = 1'b0;
  logic [7:0]  m_pre = 8'd0;
  logic [7:0]  m_pc = 8'd0;
  logic [31:0] m_sh = 32'd0;
  logic        e_rv = 1'b0;
  logic [31:0] e_rd = 32'd0;
  logic        e_irq = 1'b0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    case (a)
      3'd0:    return m_time[31:0];
      3'd1:    return m_sh;
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {16'd0, m_pre, 6'd0, m_ien, m_en};
      3'd5:    return {31'd0, m_time >= m_cmp};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock) begin : model
    logic tk;
    if (reset) begin
      m_time = 64'd0; m_cmp = '1; m_en = 1'b0; m_ien = 1'b0; m_pre = 8'd0;
      m_pc = 8'd0; m_sh = 32'd0; e_rv = 1'b0; e_rd = 32'd0; e_irq = 1'b0;
    end else begin
      e_irq = m_ien && (m_time >= m_cmp);
      e_rv  = read && !write;
      if (e_rv) begin
        e_rd = model_reg(address);
        if (address == 3'd0) m_sh = m_time[63:32];
      end
      tk = m_en && (m_pc == m_pre);
      if (m_en) m_pc = tk ? 8'd0 : m_pc + 8'd1;
      if (write) begin
        case (address)
          3'd0: m_time[31:0]  = lanes(m_time[31:0], writedata, byteenable);
          3'd1: m_time[63:32] = lanes(m_time[63:32], writedata, byteenable);
          3'd2: m_cmp[31:0]   = lanes(m_cmp[31:0], writedata, byteenable);
          3'd3: m_cmp[63:32]  = lanes(m_cmp[63:32], writedata, byteenable);
          3'd4: begin
            if (byteenable[0]) begin m_en = writedata[0]; m_ien = writedata[1]; end
            if (byteenable[1]) m_pre = writedata[15:8];
          end
          default: ;
        endcase
      end
      if (tk && !(write && address <= 3'd1)) m_time = m_time + 64'd1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clock);
      if (reset) begin
        check("rst_waitrequest", waitrequest, 1);
        check("rst_rvalid", readdatavalid, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", readdata, 0);
      end else begin
        check("waitrequest", waitrequest, 0);
        check("rvalid", readdatavalid, e_rv);
        check("irq", irq, e_irq);
        check("rdata", readdata, e_rd);
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clock); #1;
    write = 1'b1; address = a; writedata = d; byteenable = be;
    @(posedge clock); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clock); #1;
    read = 1'b1; address = a;
    @(posedge clock); #1;
    read = 1'b0;
    @(negedge clock);
    check("rd_valid", readdatavalid, 1);
    d = readdata;
  endtask

  task automatic rdx(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] lo, hi;
    // Reset values
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    rdx("reset_mtime_lo", 3'd0, 32'h0);
    rdx("reset_mtime_hi", 3'd1, 32'h0);
    rdx("reset_cmp_lo", 3'd2, 32'hFFFF_FFFF);
    rdx("reset_cmp_hi", 3'd3, 32'hFFFF_FFFF);
    rdx("reset_ctrl", 3'd4, 32'h0);
    rdx("reset_status", 3'd5, 32'h0);

    // Prescale 3: one tick every 4 cycles; 41 cycles after the write gives 10 ticks.
    wr(3'd4, 32'h0000_0301, 4'hF);
    repeat (40) @(posedge clock);
    rdx("prescale_count", 3'd0, 32'd10);
    rdx("ctrl_readback", 3'd4, 32'h0000_0301);

    // Carry into the upper half and shadowed high read.
    do_reset();
    wr(3'd0, 32'hFFFF_FFFE, 4'hF);
    wr(3'd4, 32'h1, 4'hF);
    repeat (3) @(posedge clock);
    @(posedge clock); #1;
    read = 1'b1; address = 3'd0;
    @(posedge clock); #1;
    address = 3'd1;
    @(negedge clock);
    check("b2b_lo_valid", readdatavalid, 1);
    lo = readdata;
    @(posedge clock); #1;
    read = 1'b0;
    @(negedge clock);
    check("b2b_hi_valid", readdatavalid, 1);
    hi = readdata;
    check("carry_lo", lo, 32'd2);
    check("carry_hi", hi, 32'd1);
    wr(3'd1, 32'd7, 4'hF);
    rdx("shadow_held", 3'd1, 32'd1);

    // Interrupt rises one cycle after mtime reaches mtimecmp.
    do_reset();
    wr(3'd2, 32'd100, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd0, 32'd90, 4'hF);
    wr(3'd4, 32'h3, 4'hF);
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("irq_before", irq, 0);
    @(posedge clock);
    @(negedge clock);
    check("irq_rise", irq, 1);
    rdx("status_set", 3'd5, 32'd1);
    wr(3'd2, 32'd1000, 4'hF);
    @(negedge clock);
    check("irq_still_high", irq, 1);
    @(posedge clock);
    @(negedge clock);
    check("irq_fall", irq, 0);
    rdx("status_clear", 3'd5, 32'd0);
    wr(3'd2, 32'd50, 4'hF);
    wr(3'd4, 32'h1, 4'hF);
    rdx("status_no_irq_en", 3'd5, 32'd1);
    check("irq_masked", irq, 0);

    // Byte lanes, read/write collision, write-over-tick.
    do_reset();
    wr(3'd2, 32'hAABB_CCDD, 4'b0101);
    rdx("byteenable", 3'd2, 32'hFFBB_FFDD);
    @(posedge clock); #1;
    read = 1'b1; write = 1'b1; address = 3'd3; writedata = 32'h1234_5678; byteenable = 4'hF;
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clock);
    check("collision_no_valid", readdatavalid, 0);
    rdx("collision_write", 3'd3, 32'h1234_5678);
    wr(3'd4, 32'h1, 4'hF);
    wr(3'd0, 32'h500, 4'hF);
    rdx("write_beats_tick", 3'd0, 32'h501);

    // Reset arriving with a read response pending.
    @(posedge clock); #1;
    read = 1'b1; address = 3'd2;
    @(posedge clock); #1;
    read = 1'b0; reset = 1'b1;
    @(negedge clock);
    check("midreset_rvalid", readdatavalid, 0);
    check("midreset_wait", waitrequest, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    rdx("post_reset_cmp", 3'd2, 32'hFFFF_FFFF);
    rdx("post_reset_ctrl", 3'd4, 32'h0);
    rdx("post_reset_mtime", 3'd0, 32'h0);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clarvi_avalon_timer.md
# clarvi_avalon_timer

Avalon-MM slave timer peripheral that answers the CPU's data-memory port and drives its external interrupt input. Provides a free-running 64-bit `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp` compare register. It raises a level interrupt when the counter reaches the compare value. It sits on the data interconnect beside data RAM and meets the core's fixed 1-cycle read-latency requirement.

## Interface
- `ADDR_WIDTH`, default 3: word-address width of the slave port.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `avs_s0_address`  in  ADDR_WIDTH  word address of the register.
- `avs_s0_byteenable`  in  4  byte lanes for writes; ignored on reads.
- `avs_s0_read`  in  1  read request.
- `avs_s0_readdata`  out  32  read data, valid when `avs_s0_readdatavalid` is high.
- `avs_s0_readdatavalid`  out  1  read response strobe.
- `avs_s0_write`  in  1  write request.
- `avs_s0_writedata`  in  32  write data.
- `avs_s0_waitrequest`  out  1  stall; equals `reset`, otherwise 0.
- `inr_irq`  out  1  timer interrupt, active high, level.

## Operation
- Register map, by word address:
  - 0 `MTIME_LO`: R/W.
  - 1 `MTIME_HI`: R/W. A read returns the shadow value.
  - 2 `MTIMECMP_LO`: R/W.
  - 3 `MTIMECMP_HI`: R/W.
  - 4 `CTRL`: R/W. Bit 0 `EN`, bit 1 `IRQ_EN`, bits [15:8] `PRESCALE`. Other bits read 0.
  - 5 `STATUS`: RO. Bit 0 is `mtime >= mtimecmp`. Other bits read 0.
  - 6–7 and above: reads return 0; writes are ignored.
- Writes honour `byteenable` per lane. Disabled lanes keep their old value. Writes to RO fields are ignored.
- Prescaler:
  - 8-bit `pcount` runs while `EN`=1.
  - When `pcount == PRESCALE`: `pcount` wraps to 0 and `mtime` increments by 1.
  - Otherwise `pcount` increments.
  - `PRESCALE`=0 means `mtime` increments every cycle.
  - `EN`=0 freezes both `pcount` and `mtime`. `pcount` is not cleared.
- `mtime` is 64-bit unsigned. The increment carries from LO into HI. It wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- Atomic read: a read of `MTIME_LO` returns `mtime[31:0]` and, on the same edge, captures `mtime[63:32]` into `hi_shadow`. A read of `MTIME_HI` returns `hi_shadow`. `hi_shadow` resets to 0.
- Write to `MTIME_LO` or `MTIME_HI`:
  - The written half takes the write data; the other half keeps its current value.
  - There is no increment that cycle, so the write wins over the tick.
  - No carry is generated.
  - `pcount` still advances.
- Compare: unsigned 64-bit `mtime >= mtimecmp`.
- Read and write asserted together: the write is performed and the read is dropped. No `readdatavalid` is produced.
- Reset values:
  - `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `CTRL`=0, `pcount`=0, `hi_shadow`=0.
  - `readdata`=0, `readdatavalid`=0, `inr_irq`=0, `waitrequest`=1 while reset is high.

## Timing
- Read accepted at edge N (read=1, write=0, waitrequest=0):
  - `readdatavalid`=1 and `readdata` are valid for exactly cycle N+1.
  - The data reflects register values before edge N.
  - Back-to-back reads are supported, one per cycle, with no bubbles.
- When no read is accepted, `readdatavalid`=0 and `readdata` holds its last value.
- A write at edge N is visible to a read accepted at edge N+1.
- `inr_irq` is registered: `inr_irq`(N+1) = `IRQ_EN`(N) & (`mtime`(N) >= `mtimecmp`(N)).
  - It rises one cycle after the compare becomes true.
  - It falls one cycle after `mtimecmp` is raised or `IRQ_EN` is cleared.
- `STATUS` bit 0 is combinational from the registers at read-accept time. It is independent of `IRQ_EN`.
- Reset asserted mid-transaction:
  - A pending `readdatavalid` is suppressed in the cycle after reset.
  - All state returns to reset values at the reset edge.
  - Requests are not accepted while reset is high.

## Test plan
- **Reset values:** Reset 2 cycles, then read addresses 0..5 -> responses 0, 0, 0xFFFF_FFFF, 0xFFFF_FFFF, 0, 0. Each `readdatavalid` is exactly 1 cycle after its read. `inr_irq`=0 throughout.
- **Prescaler count:** Write `CTRL`=0x0000_0301 (EN, PRESCALE=3), wait 40 cycles, then read `MTIME_LO` -> value 10 (±1 depending on write-to-read offset). The counter increments every 4th cycle.
- **Carry and shadow read:**
  - Write `MTIME_HI`=0, `MTIME_LO`=0xFFFF_FFFE. Set `CTRL`=1.
  - Read LO then HI on consecutive cycles after the wrap -> HI=1, LO small. HI equals the value captured at the LO read even if further ticks occur.
- **Interrupt and clear:**
  - Set `mtimecmp`=100, `CTRL`=3, `PRESCALE`=0 with `mtime`=90.
  - -> `inr_irq` rises exactly 1 cycle after `mtime` reaches 100.
  - Write `MTIMECMP_LO`=1000 -> `inr_irq` falls 1 cycle after the write.
  - `STATUS`=1 while the compare holds, even with `IRQ_EN`=0.
- **Byteenable and collisions:**
  - Write `MTIMECMP_LO`=0xAABBCCDD with byteenable 0b0101 over 0xFFFF_FFFF -> reads 0xFFBBFFDD.
  - Read and write in the same cycle -> no `readdatavalid`, write is applied.
  - `MTIME_LO` write on a tick cycle -> the written value is held, with no +1.
- **Reset mid-read:** Read accepted, then reset asserted the next cycle -> `readdatavalid` stays 0. `waitrequest`=1 during reset. State is back at reset values.
